instr_reader: RTL

- Downstream readback stage for the instruction register.
- On a start command it walks read_pointer through a programmed window of register entries and captures each instruction_word.
- It recomputes the expected result from opc/op_a/op_b and compares it with the stored result field.
- Each checked word goes out on a valid/ready stream with a mismatch flag; a per-run error count is kept.

---
 rtl/instr_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_reader.sv
// Readback stage: walks a window of instruction register entries, recomputes
// each result from opc/op_a/op_b and streams the word out with a mismatch flag.
package instr_reader_pkg;
    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    typedef struct packed {
        logic [3:0]        opc;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] result;
    } instruction_t;
endpackage

module instr_reader
    import instr_reader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_ptr,
    input  logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] read_pointer,
    input  instruction_t      instruction_word,
    output logic              out_valid,
    input  logic              out_ready,
    output instruction_t      out_iw,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_mismatch,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] remaining;
    logic             last;

    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] b_safe;
    logic signed [DATA_W-1:0] expected;
    logic                     div_zero;
    logic                     mismatch;

    // Divisor is forced non-zero so no X reaches the compare; div_zero
    // then overrides the result.
    always_comb begin
        a        = instruction_word.op_a;
        b        = instruction_word.op_b;
        b_safe   = (b == '0) ? DATA_W'(1) : b;
        expected = '0;
        div_zero = 1'b0;
        unique case (instruction_word.opc)
            OP_ZERO:  expected = '0;
            OP_PASSA: expected = a;
            OP_PASSB: expected = b;
            OP_ADD:   expected = a + b;
            OP_SUB:   expected = a - b;
            OP_MULT:  expected = a * b;
            OP_DIV: begin
                expected = a / b_safe;
                div_zero = (b == '0);
            end
            OP_MOD: begin
                expected = a % b_safe;
                div_zero = (b == '0);
            end
            default:  expected = '0;
        endcase
        mismatch = div_zero ||
                   (expected != instruction_word.result);
    end

    assign last      = (remaining == CNT_W'(1));
    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = PRESENT;
            PRESENT: if (out_ready) state_nx = last ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_pointer <= '0;
            remaining    <= '0;
            out_iw       <= '0;
            out_index    <= '0;
            out_mismatch <= 1'b0;
            err_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        read_pointer <= first_ptr;
                        remaining    <= (count == '0) ? CNT_W'(DEPTH) : count;
                        err_count    <= '0;
                    end
                end
                FETCH: begin
                    out_iw       <= instruction_word;
                    out_index    <= read_pointer;
                    out_mismatch <= mismatch;
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (out_mismatch) err_count <= err_count + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        // DEPTH is a power of two, so the pointer wraps naturally
                        if (!last) read_pointer <= read_pointer + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
